mealy_seq_detect: RTL and testbench

//  Downstream consumer of the clk_pulse debouncer/single-pulse stage. Takes the clean
//  one-cycle strobes for a '0' key and a '1' key and runs a Mealy sequence detector

---
 rtl/mealy_seq_detect.sv | 111 +++++++++++
 tb/tb_mealy_seq_detect.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mealy_seq_detect.sv
// Mealy detector for a parameterised bit pattern fed by one-cycle '0'/'1' key strobes.
// Keeps a fill-gated bit history, a saturating match counter and a conflict flag.
module mealy_seq_detect #(
    parameter int               LEN     = 4,
    parameter logic [LEN-1:0]   PATTERN = 4'b1011,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8
) (
    input  logic             clk_200H,
    input  logic             rst,
    input  logic             inp0_pulse,
    input  logic             inp1_pulse,
    output logic             match,
    output logic             match_q,
    output logic [CNT_W-1:0] match_count,
    output logic [LEN-1:0]   history,
    output logic [2:0]       fill,
    output logic             conflict
);

    // fill is held one bit wider internally so that LEN=8 can be represented
    localparam logic [3:0] LEN_C = 4'(LEN);

    logic [LEN-1:0]   history_r;
    logic [3:0]       fill_r;
    logic [CNT_W-1:0] count_r;
    logic             match_q_r;
    logic             conflict_r;

    logic [LEN-1:0]   history_n_s;
    logic [3:0]       fill_n_s;
    logic [CNT_W-1:0] count_n_s;
    logic             accepted_s;
    logic             bit_s;
    logic [LEN-1:0]   cand_s;
    logic             match_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_W'(1'b1);
        end
    endfunction

    // Candidate window and zero-latency match decision
    always_comb begin
        accepted_s = inp0_pulse ^ inp1_pulse;
        bit_s      = inp1_pulse;
        cand_s     = {history_r[LEN-2:0], bit_s};
        match_s    = 1'b0;
        if (!rst && accepted_s && (fill_r >= (LEN_C - 4'd1)) && (cand_s == PATTERN)) begin
            match_s = 1'b1;
        end else begin
            match_s = 1'b0;
        end
    end

    // Next-state for history, fill and match counter
    always_comb begin
        history_n_s = history_r;
        fill_n_s    = fill_r;
        count_n_s   = count_r;
        if (match_s) begin
            count_n_s = sat_inc(count_r);
            if (OVERLAP != 1'b0) begin
                history_n_s = cand_s;
                fill_n_s    = LEN_C;
            end else begin
                history_n_s = '0;
                fill_n_s    = 4'd0;
            end
        end else if (accepted_s) begin
            history_n_s = cand_s;
            if (fill_r >= LEN_C) begin
                fill_n_s = LEN_C;
            end else begin
                fill_n_s = fill_r + 4'd1;
            end
        end else begin
            history_n_s = history_r;
            fill_n_s    = fill_r;
            count_n_s   = count_r;
        end
    end

    // State and registered flag update
    always_ff @(posedge clk_200H or posedge rst) begin
        if (rst) begin
            history_r  <= '0;
            fill_r     <= 4'd0;
            count_r    <= '0;
            match_q_r  <= 1'b0;
            conflict_r <= 1'b0;
        end else begin
            history_r  <= history_n_s;
            fill_r     <= fill_n_s;
            count_r    <= count_n_s;
            match_q_r  <= match_s;
            conflict_r <= inp0_pulse & inp1_pulse;
        end
    end

    assign match       = match_s;
    assign match_q     = match_q_r;
    assign match_count = count_r;
    assign history     = history_r;
    assign fill        = (fill_r > 4'd7) ? 3'd7 : fill_r[2:0];
    assign conflict    = conflict_r;

endmodule

// File: tb/tb_mealy_seq_detect.sv
// Scoreboard bench: three detector configurations share one randomized strobe stream
// and are checked every cycle against an arithmetic reference model.
module tb_mealy_seq_detect;

    localparam int NCFG = 3;

    logic clk_200H = 1'b0;
    logic rst      = 1'b1;
    logic inp0_pulse = 1'b0;
    logic inp1_pulse = 1'b0;

    always #5 clk_200H = ~clk_200H;

    logic       m_w    [NCFG];
    logic       mq_w   [NCFG];
    logic [7:0] cnt_w  [NCFG];
    logic [3:0] hist_w [NCFG];
    logic [2:0] fill_w [NCFG];
    logic       conf_w [NCFG];

    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
    logic [1:0] cnt_c;

    // cfg 0: 1011 overlapping; cfg 1: 0011 non-overlapping, 2-bit count; cfg 2: 1011 overlapping, 2-bit count
    mealy_seq_detect #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_dut (
        .clk_200H(clk_200H), .rst(rst), .inp0_pulse(inp0_pulse), .inp1_pulse(inp1_pulse),
        .match(m_w[0]), .match_q(mq_w[0]), .match_count(cnt_a), .history(hist_w[0]),
        .fill(fill_w[0]), .conflict(conf_w[0]));

    mealy_seq_detect #(.LEN(4), .PATTERN(4'b0011), .OVERLAP(1'b0), .CNT_W(2)) u_dut_b (
        .clk_200H(clk_200H), .rst(rst), .inp0_pulse(inp0_pulse), .inp1_pulse(inp1_pulse),
        .match(m_w[1]), .match_q(mq_w[1]), .match_count(cnt_b), .history(hist_w[1]),
        .fill(fill_w[1]), .conflict(conf_w[1]));

    mealy_seq_detect #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) u_dut_c (
        .clk_200H(clk_200H), .rst(rst), .inp0_pulse(inp0_pulse), .inp1_pulse(inp1_pulse),
        .match(m_w[2]), .match_q(mq_w[2]), .match_count(cnt_c), .history(hist_w[2]),
        .fill(fill_w[2]), .conflict(conf_w[2]));

    assign cnt_w[0] = cnt_a;
    assign cnt_w[1] = {6'd0, cnt_b};
    assign cnt_w[2] = {6'd0, cnt_c};

    typedef struct {
        int         cfg;
        logic       m;
        logic       mq;
        logic [7:0] cnt;
        logic [3:0] hist;
        logic [2:0] fill;
        logic       conf;
    } exp_t;

    exp_t exp_q[$];

    // reference model: bits received since last flush, value of the newest bits, counts
    int recv   [NCFG];
    int val    [NCFG];
    int cnt    [NCFG];
    bit mq_m   [NCFG];
    bit conf_m [NCFG];
    int pat    [NCFG];
    bit ovl    [NCFG];
    int cmax   [NCFG];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int cfg, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cfg%0d @%0t: got %0h expected %0h", name, cfg, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCFG; c++) begin
            recv[c] = 0; val[c] = 0; cnt[c] = 0; mq_m[c] = 1'b0; conf_m[c] = 1'b0;
        end
    endtask

    // code: 0 idle, 1 bit '0', 2 bit '1', 3 both strobes
    task automatic drive(input int code);
        bit acc, b, m;
        int nv;
        exp_t e;
        @(negedge clk_200H);
        #1;
        inp0_pulse = (code == 1) || (code == 3);
        inp1_pulse = (code == 2) || (code == 3);
        acc = (code == 1) || (code == 2);
        b   = (code == 2);
        for (int c = 0; c < NCFG; c++) begin
            nv = (val[c] * 2 + int'(b)) % 16;
            m  = acc && (recv[c] + 1 >= 4) && (nv == pat[c]);
            e.cfg  = c;
            e.m    = m;
            e.mq   = mq_m[c];
            e.cnt  = 8'(cnt[c]);
            e.hist = 4'(val[c]);
            e.fill = 3'((recv[c] > 4) ? 4 : recv[c]);
            e.conf = conf_m[c];
            exp_q.push_back(e);
            mq_m[c]   = m;
            conf_m[c] = (code == 3);
            if (m) begin
                cnt[c] = (cnt[c] + 1 > cmax[c]) ? cmax[c] : cnt[c] + 1;
                if (ovl[c]) begin
                    val[c] = nv; recv[c] = recv[c] + 1;
                end else begin
                    val[c] = 0; recv[c] = 0;
                end
            end else if (acc) begin
                val[c] = nv; recv[c] = recv[c] + 1;
            end
        end
    endtask

    // asynchronous reset asserted mid-cycle, outputs checked before the next edge
    task automatic do_reset();
        @(negedge clk_200H);
        #2;
        inp0_pulse = 1'b0;
        inp1_pulse = 1'b1;
        rst = 1'b1;
        #1;
        for (int c = 0; c < NCFG; c++) begin
            chk("rst_match", c, 32'(m_w[c]), 32'd0);
            chk("rst_match_q", c, 32'(mq_w[c]), 32'd0);
            chk("rst_count", c, 32'(cnt_w[c]), 32'd0);
            chk("rst_history", c, 32'(hist_w[c]), 32'd0);
            chk("rst_fill", c, 32'(fill_w[c]), 32'd0);
            chk("rst_conflict", c, 32'(conf_w[c]), 32'd0);
        end
        @(negedge clk_200H);
        #2;
        inp1_pulse = 1'b0;
        rst = 1'b0;
        model_reset();
    endtask

    // monitor: pops one record per configuration each cycle, just before the rising edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_200H);
            #4;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("match", e.cfg, 32'(m_w[e.cfg]), 32'(e.m));
                chk("match_q", e.cfg, 32'(mq_w[e.cfg]), 32'(e.mq));
                chk("match_count", e.cfg, 32'(cnt_w[e.cfg]), 32'(e.cnt));
                chk("history", e.cfg, 32'(hist_w[e.cfg]), 32'(e.hist));
                chk("fill", e.cfg, 32'(fill_w[e.cfg]), 32'(e.fill));
                chk("conflict", e.cfg, 32'(conf_w[e.cfg]), 32'(e.conf));
            end
        end
    end

    initial begin
        int seq_a [] = '{2, 1, 2, 2, 1, 2, 2, 0, 2, 1, 3, 2, 2, 0};
        int seq_b [] = '{2, 2, 1, 1, 2, 2};
        pat[0] = 11; ovl[0] = 1'b1; cmax[0] = 255;
        pat[1] = 3;  ovl[1] = 1'b0; cmax[1] = 3;
        pat[2] = 11; ovl[2] = 1'b1; cmax[2] = 3;
        model_reset();
        #12;
        rst = 1'b0;

        do_reset();
        foreach (seq_a[i]) drive(seq_a[i]);
        drive(2); drive(1); drive(2);
        do_reset();
        foreach (seq_b[i]) drive(seq_b[i]);
        for (int k = 0; k < 5; k++) begin
            drive(1); drive(1); drive(2); drive(2);
        end
        for (int k = 0; k < 5; k++) begin
            drive(1); drive(2); drive(2);
        end
        for (int n = 0; n < 600; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (n == 300) do_reset();
            if (r == 0)      drive(0);
            else if (r == 1) drive(3);
            else if (r < 6)  drive(1);
            else             drive(2);
        end
        drive(0); drive(0); drive(0);
        repeat (2) @(posedge clk_200H);
        chk("scoreboard_drained", 0, 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
